mdu_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the execute-stage ALU. It accepts one operation at a time from execute (operands plus funct3). It computes over multiple cycles at 1 bit per cycle and holds the pipeline via `stall_req` until it returns a WIDTH-bit result with a one-cycle `done` pulse. Execute muxes `result` onto its result path in the `done` cycle.

---
 rtl/mdu_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide unit beside the execute ALU.
// Takes one op at a time and retires one result bit per cycle.
// Multiply is shift-add; divide is restoring shift-subtract. Both run on
// operand magnitudes, and the signs are fixed up in a final cycle.
//
// Ports
//   clk, rst_n      rising-edge clock, async active-low reset
//   start, kill     request (taken only in IDLE) / abort (pipeline flush)
//   funct3          RV32M op select
//   rs1_data        dividend / multiplicand
//   rs2_data        divisor / multiplier
//   busy            high in RUN and FIX
//   done            one-cycle pulse; result is valid in this cycle
//   result          registered result, held until the next completion
//   stall_req       combinational hold request to the pipeline
//
// Optional feature: define MDU_EARLY_OUT_EN to finish divide-by-zero,
// signed overflow and multiply-by-zero directly from IDLE (done at N+1).
//
// state | meaning
// IDLE  | waiting for start; latch operands on accept
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction, result select, register result
// DONE  | done pulse, result valid

`ifndef WIDTH
`define WIDTH 32
`endif

module mdu_sequencer #(
  parameter int WIDTH = `WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             stall_req
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               sgn1_q, sgn1_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode in IDLE
  logic             is_div;
  logic             rs1_signed, rs2_signed;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_zero;
  logic             accept;

  always_comb begin
    is_div     = funct3[2];
    rs1_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV)  || (funct3 == F_REM);
    rs2_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    s1         = rs1_signed && rs1_data[WIDTH-1];
    s2         = rs2_signed && rs2_data[WIDTH-1];
    mag1       = s1 ? -rs1_data : rs1_data;
    mag2       = s2 ? -rs2_data : rs2_data;
    div_zero   = is_div && (rs2_data == '0);
    accept     = (state_q == S_IDLE) && start && !kill;
  end

`ifdef MDU_EARLY_OUT_EN
  logic             early_hit;
  logic [WIDTH-1:0] early_res;
  logic             sdiv_ovf;
  logic             mul_zero;

  always_comb begin
    sdiv_ovf  = is_div && !funct3[0] &&
                (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_data == '1);
    mul_zero  = !is_div && ((rs1_data == '0) || (rs2_data == '0));
    early_hit = 1'b0;
    early_res = '0;
    if (div_zero) begin
      early_hit = 1'b1;
      early_res = funct3[1] ? rs1_data : '1;
    end else if (sdiv_ovf) begin
      early_hit = 1'b1;
      early_res = funct3[1] ? '0 : rs1_data;
    end else if (mul_zero) begin
      early_hit = 1'b1;
      early_res = '0;
    end
  end
`else
  logic early_hit;
  assign early_hit = 1'b0;
`endif

  // One iteration of each algorithm.
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_addend = acc_q[0] ? opa_q : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
    // The top bit of the trial is the borrow; it is set only when the
    // shifted remainder is smaller than the divisor.
    div_trial  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
    if (!div_trial[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
  end

  // Sign fix-up and result select
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo, rem, fix_res;

  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      F_MUL:                      fix_res = prod_s[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU:  fix_res = prod_s[2*WIDTH-1:WIDTH];
      F_DIV, F_DIVU:              fix_res = dz_q ? '1 : (neg_q ? -quo : quo);
      F_REM, F_REMU:              fix_res = sgn1_q ? -rem : rem;
      default:                    fix_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !kill) state_d = early_hit ? S_DONE : S_RUN;
      S_RUN: begin
        if (kill)                  state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX:  state_d = kill ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_FIX);
    done      = (state_q == S_DONE) && !kill;
    stall_req = accept || busy;
  end
  assign result = result_q;

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    sgn1_d   = sgn1_q;
    dz_d     = dz_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = funct3;
          opa_d  = mag1;
          opb_d  = mag2;
          neg_d  = s1 ^ s2;
          sgn1_d = s1;
          dz_d   = div_zero;
          cnt_d  = '0;
          acc_d  = is_div ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
`ifdef MDU_EARLY_OUT_EN
          if (early_hit) result_d = early_res;
`endif
        end
      end
      S_RUN: begin
        if (!kill) begin
          cnt_d = cnt_q + CW'(1);
          acc_d = op_q[2] ? div_next : mul_next;
        end
      end
      S_FIX: begin
        if (!kill) result_d = fix_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sgn1_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      sgn1_q   <= sgn1_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer. An arithmetic reference model predicts
// the result, the done cycle, busy and stall_req. These are checked against
// the DUT on every cycle. Directed ops also check against literal results.

module tb_mdu_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [2:0]   funct3 = 3'b000;
  logic [W-1:0] rs1_data = '0;
  logic [W-1:0] rs2_data = '0;
  logic         busy, done, stall_req;
  logic [W-1:0] result;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .busy(busy), .done(done),
    .result(result), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    if (f[2] && b == 0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    if (!f[2] && (a == 0 || b == 0)) return 1'b1;
    return 1'b0;
  endfunction

  // Model: lat counts the cycle index within the op (1 = cycle after accept)
  bit           m_active = 1'b0;
  bit           m_early = 1'b0;
  int           m_lat = 0;
  int           m_done_lat = 0;
  logic [W-1:0] m_exp = '0;
  logic [W-1:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_res    = '0;
    end else if (m_active) begin
      if (kill) m_active = 1'b0;
      else if (m_lat == m_done_lat) m_active = 1'b0;
      else begin
        m_lat++;
        if (m_lat == m_done_lat) m_res = m_exp;
      end
    end else if (start && !kill) begin
      m_active = 1'b1;
      m_lat    = 1;
      m_exp    = ref_op(funct3, rs1_data, rs2_data);
`ifdef MDU_EARLY_OUT_EN
      m_early  = is_special(funct3, rs1_data, rs2_data);
`else
      m_early  = 1'b0;
`endif
      m_done_lat = m_early ? 1 : W + 2;
      if (m_lat == m_done_lat) m_res = m_exp;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_done, e_busy, e_stall;
      e_done  = m_active && (m_lat == m_done_lat) && !kill;
      e_busy  = m_active && !m_early && (m_lat <= W + 1);
      e_stall = (!m_active && start && !kill) || e_busy;
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("stall_req", {31'b0, stall_req}, {31'b0, e_stall});
      chk("result", result, m_res);
    end
  end

  // Caller is positioned just after a rising edge
  task automatic wait_done(input logic [W-1:0] exp, input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vecs++;
      errs++;
      $display("FAIL %s timeout: done got 0, expected 1 within 60 cycles", nm);
    end else begin
      chk(nm, result, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string nm);
    funct3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(exp, nm);
  endtask

  initial begin
    // Pin the model to hand-computed values
    chk("model_mulh",  ref_op(3'd1, 32'hFFFF_FFFE, 32'h3), 32'hFFFF_FFFF);
    chk("model_mulhu", ref_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("model_div",   ref_op(3'd4, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
    chk("model_rem",   ref_op(3'd6, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
    chk("model_ovf",   ref_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    // Reset with start held
    #2 rst_n = 1'b0;
    funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;       // accepted on the first edge after release
    start = 1'b0;
    wait_done(32'd14, "divu_after_reset");

    do_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "mulh");
    do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, "mul");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_neg");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min");
    do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem");
    do_op(3'd4, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, "div_negdivisor");
    do_op(3'd6, 32'd20, 32'hFFFF_FFFA, 32'd2, "rem_negdivisor");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
    do_op(3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, "divu_by0");
    do_op(3'd7, 32'd5, 32'h0, 32'd5, "remu_by0");
    do_op(3'd4, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, "div_by0");
    do_op(3'd6, 32'h8000_0000, 32'h0, 32'h8000_0000, "rem_by0");
    do_op(3'd0, 32'h0000_1234, 32'h0, 32'h0, "mul_by0");
    do_op(3'd1, 32'h0, 32'hFFFF_FFFF, 32'h0, "mulh_zero");

    // Kill at cycle N+10 of a DIV: no done, result unchanged, then restart
    funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'h0);
    chk("kill_result", result, 32'h0);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_after_kill");

    // Start pulsed during RUN is ignored
    funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(32'd14, "divu_start_ignored");
    repeat (5) @(posedge clk);
    #1;

    // Reset mid-operation: no done, result cleared
    do_op(3'd7, 32'd9, 32'd4, 32'd1, "remu_before_reset");
    funct3 = 3'd0; rs1_data = 32'd6; rs2_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2 chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_result", result, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    do_op(3'd0, 32'd6, 32'd7, 32'd42, "mul_after_reset");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
